// File: rtl/de_hazard_ctrl.sv
// de_hazard_ctrl: decode-stage hazard/trap sequencer (load-use stall, branch wait,
// ECALL drain + MTVEC redirect) with a saturating bubble-cycle counter.  Rev 1.0
`default_nettype none

module de_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             DE_V,
  input  logic [31:0]      DE_IR,
  input  logic             EXE_V,
  input  logic [31:0]      EXE_IR,
  input  logic             MEM_STALL,
  input  logic             EXE_BR_RESOLVED,
  input  logic             EXE_BR_TAKEN,
  output logic             FE_STALL,
  output logic             DE_STALL,
  output logic             DE_BUBBLE,
  output logic             FE_FLUSH,
  output logic [1:0]       PC_SEL,
  output logic             TRAP_CS,
  output logic [63:0]      TRAP_CAUSE,
  output logic [CNT_W-1:0] STALL_CNT
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES - 1);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [31:0] ECALL    = 32'h0000_0073;

  typedef enum logic [1:0] {
    S_RUN           = 2'd0,
    S_BR_WAIT       = 2'd1,
    S_TRAP_DRAIN    = 2'd2,
    S_TRAP_REDIRECT = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [DW-1:0]     drain_q, drain_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              first_q;

  logic [6:0] w_de_op;
  logic [4:0] w_exe_rd;
  logic       w_rs1_used;
  logic       w_rs2_used;
  logic       w_load_use;
  logic       w_ctrl_flow;
  logic       w_quiet;
  logic       w_unused_exe_ir;

  assign w_de_op         = DE_IR[6:0];
  assign w_exe_rd        = EXE_IR[11:7];
  assign w_unused_exe_ir = ^EXE_IR[31:12];

  // CSR immediate forms (funct3[2]=1) carry a zimm in the rs1 field, not a register.
  assign w_rs1_used = !((w_de_op == OP_LUI) || (w_de_op == OP_AUIPC) || (w_de_op == OP_JAL) ||
                        ((w_de_op == OP_SYSTEM) && DE_IR[14]));
  assign w_rs2_used = (w_de_op == OP_OP) || (w_de_op == OP_OP32) ||
                      (w_de_op == OP_STORE) || (w_de_op == OP_BRANCH);

  assign w_load_use = EXE_V && (EXE_IR[6:0] == OP_LOAD) && (w_exe_rd != 5'd0) &&
                      ((w_rs1_used && (DE_IR[19:15] == w_exe_rd)) ||
                       (w_rs2_used && (DE_IR[24:20] == w_exe_rd)));

  assign w_ctrl_flow = (w_de_op == OP_BRANCH) || (w_de_op == OP_JAL) || (w_de_op == OP_JALR);

  // Outputs stay quiet during reset and for the first cycle after release.
  assign w_quiet = reset || first_q;

  always_comb begin
    FE_STALL   = 1'b0;
    DE_STALL   = 1'b0;
    DE_BUBBLE  = 1'b0;
    FE_FLUSH   = 1'b0;
    PC_SEL     = 2'd0;
    TRAP_CS    = 1'b0;
    TRAP_CAUSE = 64'd0;
    state_d    = state_q;
    drain_d    = drain_q;
    if (!w_quiet) begin
      if (MEM_STALL) begin
        FE_STALL = 1'b1;
        DE_STALL = 1'b1;
      end else begin
        case (state_q)
          S_RUN: begin
            if (DE_V) begin
              if (w_load_use) begin
                FE_STALL  = 1'b1;
                DE_STALL  = 1'b1;
                DE_BUBBLE = 1'b1;
              end else if (DE_IR == ECALL) begin
                state_d = S_TRAP_DRAIN;
                drain_d = DRAIN_INIT;
              end else if (w_ctrl_flow) begin
                state_d = S_BR_WAIT;
              end
            end
          end
          S_BR_WAIT: begin
            FE_STALL  = 1'b1;
            DE_STALL  = 1'b1;
            DE_BUBBLE = 1'b1;
            if (EXE_BR_RESOLVED) begin
              FE_STALL = 1'b0;
              FE_FLUSH = EXE_BR_TAKEN;
              PC_SEL   = EXE_BR_TAKEN ? 2'd1 : 2'd0;
              state_d  = S_RUN;
            end
          end
          S_TRAP_DRAIN: begin
            FE_STALL  = 1'b1;
            DE_STALL  = 1'b1;
            DE_BUBBLE = 1'b1;
            if (drain_q == '0) begin
              state_d = S_TRAP_REDIRECT;
            end else begin
              drain_d = drain_q - DW'(1);
            end
          end
          default: begin
            TRAP_CS    = 1'b1;
            TRAP_CAUSE = 64'd11;
            PC_SEL     = 2'd2;
            FE_FLUSH   = 1'b1;
            DE_BUBBLE  = 1'b1;
            state_d    = S_RUN;
          end
        endcase
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (DE_BUBBLE && !MEM_STALL && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= S_RUN;
      drain_q <= '0;
      cnt_q   <= '0;
      first_q <= 1'b1;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      cnt_q   <= cnt_d;
      first_q <= 1'b0;
    end
  end

  assign STALL_CNT = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_de_hazard_ctrl.sv
// tb_de_hazard_ctrl: directed scoreboard bench for de_hazard_ctrl (32-bit and 4-bit counter
// instances driven in parallel).
`default_nettype none

module tb_de_hazard_ctrl;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        DE_V = 1'b0;
  logic [31:0] DE_IR = 32'h13;
  logic        EXE_V = 1'b0;
  logic [31:0] EXE_IR = 32'h13;
  logic        MEM_STALL = 1'b0;
  logic        EXE_BR_RESOLVED = 1'b0;
  logic        EXE_BR_TAKEN = 1'b0;

  logic        FE_STALL, DE_STALL, DE_BUBBLE, FE_FLUSH, TRAP_CS;
  logic [1:0]  PC_SEL;
  logic [63:0] TRAP_CAUSE;
  logic [31:0] STALL_CNT;

  logic        FE_STALL4, DE_STALL4, DE_BUBBLE4, FE_FLUSH4, TRAP_CS4;
  logic [1:0]  PC_SEL4;
  logic [63:0] TRAP_CAUSE4;
  logic [3:0]  STALL_CNT4;

  de_hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(32)) dut (
    .CLK(CLK), .reset(reset), .DE_V(DE_V), .DE_IR(DE_IR), .EXE_V(EXE_V), .EXE_IR(EXE_IR),
    .MEM_STALL(MEM_STALL), .EXE_BR_RESOLVED(EXE_BR_RESOLVED), .EXE_BR_TAKEN(EXE_BR_TAKEN),
    .FE_STALL(FE_STALL), .DE_STALL(DE_STALL), .DE_BUBBLE(DE_BUBBLE), .FE_FLUSH(FE_FLUSH),
    .PC_SEL(PC_SEL), .TRAP_CS(TRAP_CS), .TRAP_CAUSE(TRAP_CAUSE), .STALL_CNT(STALL_CNT)
  );

  de_hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(4)) dut4 (
    .CLK(CLK), .reset(reset), .DE_V(DE_V), .DE_IR(DE_IR), .EXE_V(EXE_V), .EXE_IR(EXE_IR),
    .MEM_STALL(MEM_STALL), .EXE_BR_RESOLVED(EXE_BR_RESOLVED), .EXE_BR_TAKEN(EXE_BR_TAKEN),
    .FE_STALL(FE_STALL4), .DE_STALL(DE_STALL4), .DE_BUBBLE(DE_BUBBLE4), .FE_FLUSH(FE_FLUSH4),
    .PC_SEL(PC_SEL4), .TRAP_CS(TRAP_CS4), .TRAP_CAUSE(TRAP_CAUSE4), .STALL_CNT(STALL_CNT4)
  );

  always #5 CLK = ~CLK;

  localparam logic [31:0] LD_X5  = {12'd0, 5'd1, 3'b011, 5'd5, 7'b0000011};
  localparam logic [31:0] LD_X0  = {12'd0, 5'd1, 3'b011, 5'd0, 7'b0000011};
  localparam logic [31:0] ADD_R5 = {7'd0, 5'd7, 5'd5, 3'b000, 5'd6, 7'b0110011};
  localparam logic [31:0] ADD_R0 = {7'd0, 5'd7, 5'd0, 3'b000, 5'd6, 7'b0110011};
  localparam logic [31:0] LUI_X5 = {12'd0, 5'd5, 3'b000, 5'd6, 7'b0110111};
  localparam logic [31:0] SD_R5  = {7'd0, 5'd5, 5'd2, 3'b011, 5'd0, 7'b0100011};
  localparam logic [31:0] BEQ    = {7'd0, 5'd2, 5'd1, 3'b000, 5'd0, 7'b1100011};
  localparam logic [31:0] JAL    = {20'd0, 5'd1, 7'b1101111};
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  typedef struct {
    string       tag;
    logic [70:0] strb;
    logic [31:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int unsigned mcnt = 0;
  int unsigned mcnt4 = 0;

  task automatic drv(input logic dv, input logic [31:0] dir, input logic ev,
                     input logic [31:0] eir, input logic ms, input logic res, input logic tk);
    DE_V = dv; DE_IR = dir; EXE_V = ev; EXE_IR = eir;
    MEM_STALL = ms; EXE_BR_RESOLVED = res; EXE_BR_TAKEN = tk;
  endtask

  // Push the expected outputs for the cycle just driven, then compare once they settle.
  task automatic cyc(input string tag, input logic fe, input logic de, input logic bub,
                     input logic fl, input logic [1:0] ps, input logic tr);
    exp_t        e;
    exp_t        o;
    logic [70:0] got;
    logic [70:0] got4;
    if (reset) begin
      mcnt  = 0;
      mcnt4 = 0;
    end
    e.tag  = tag;
    e.strb = {fe, de, bub, fl, ps, tr, (tr ? 64'd11 : 64'd0)};
    e.cnt  = mcnt;
    e.cnt4 = mcnt4[3:0];
    sb.push_back(e);
    #3;
    o    = sb.pop_front();
    got  = {FE_STALL, DE_STALL, DE_BUBBLE, FE_FLUSH, PC_SEL, TRAP_CS, TRAP_CAUSE};
    got4 = {FE_STALL4, DE_STALL4, DE_BUBBLE4, FE_FLUSH4, PC_SEL4, TRAP_CS4, TRAP_CAUSE4};
    total++;
    assert (got === o.strb) else begin
      bad++;
      $error("FAIL %s strobes: got %h want %h", o.tag, got, o.strb);
    end
    total++;
    assert (got4 === o.strb) else begin
      bad++;
      $error("FAIL %s strobes4: got %h want %h", o.tag, got4, o.strb);
    end
    total++;
    assert (STALL_CNT === o.cnt) else begin
      bad++;
      $error("FAIL %s stall_cnt: got %0d want %0d", o.tag, STALL_CNT, o.cnt);
    end
    total++;
    assert (STALL_CNT4 === o.cnt4) else begin
      bad++;
      $error("FAIL %s stall_cnt4: got %0d want %0d", o.tag, STALL_CNT4, o.cnt4);
    end
    if (bub && !MEM_STALL && !reset) begin
      mcnt++;
      if (mcnt4 < 15) mcnt4++;
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    @(posedge CLK); #1;
    // Reset held with a live load-use pattern on the inputs.
    drv(1, ADD_R5, 1, LD_X5, 0, 0, 0);
    cyc("rst_hold", 0, 0, 0, 0, 2'd0, 0);
    reset = 1'b0;
    cyc("rst_first", 0, 0, 0, 0, 2'd0, 0);
    cyc("lu_stall", 1, 1, 1, 0, 2'd0, 0);
    drv(1, ADD_R5, 0, NOP, 0, 0, 0);
    cyc("lu_release", 0, 0, 0, 0, 2'd0, 0);

    drv(1, ADD_R0, 1, LD_X0, 0, 0, 0);
    cyc("lu_rd_x0", 0, 0, 0, 0, 2'd0, 0);
    drv(1, LUI_X5, 1, LD_X5, 0, 0, 0);
    cyc("lu_lui", 0, 0, 0, 0, 2'd0, 0);
    drv(1, SD_R5, 1, LD_X5, 0, 0, 0);
    cyc("lu_rs2", 1, 1, 1, 0, 2'd0, 0);
    drv(1, SD_R5, 0, NOP, 0, 0, 0);
    cyc("lu_rs2_rel", 0, 0, 0, 0, 2'd0, 0);

    // Taken branch, resolved on the third BR_WAIT cycle.
    drv(1, BEQ, 0, NOP, 0, 0, 0);
    cyc("bt_issue", 0, 0, 0, 0, 2'd0, 0);
    drv(1, NOP, 0, NOP, 0, 0, 0);
    cyc("bt_wait1", 1, 1, 1, 0, 2'd0, 0);
    cyc("bt_wait2", 1, 1, 1, 0, 2'd0, 0);
    drv(1, NOP, 0, NOP, 0, 1, 1);
    cyc("bt_resolve", 0, 1, 1, 1, 2'd1, 0);
    cyc("bt_run_ignore", 0, 0, 0, 0, 2'd0, 0);

    // Not-taken jump with a resolve that collides with MEM_STALL.
    drv(1, JAL, 0, NOP, 0, 0, 0);
    cyc("bn_issue", 0, 0, 0, 0, 2'd0, 0);
    drv(0, NOP, 0, NOP, 0, 0, 0);
    cyc("bn_wait1", 1, 1, 1, 0, 2'd0, 0);
    drv(0, NOP, 0, NOP, 1, 1, 1);
    cyc("bn_memstall", 1, 1, 0, 0, 2'd0, 0);
    drv(0, NOP, 0, NOP, 0, 0, 0);
    cyc("bn_wait2", 1, 1, 1, 0, 2'd0, 0);
    drv(0, NOP, 0, NOP, 0, 1, 0);
    cyc("bn_resolve", 0, 1, 1, 0, 2'd0, 0);
    drv(0, NOP, 0, NOP, 0, 0, 0);
    cyc("bn_run", 0, 0, 0, 0, 2'd0, 0);

    // ECALL: three drain cycles then a one-cycle redirect.
    drv(1, ECALL, 0, NOP, 0, 0, 0);
    cyc("ec_issue", 0, 0, 0, 0, 2'd0, 0);
    drv(1, NOP, 0, NOP, 0, 0, 0);
    cyc("ec_drain1", 1, 1, 1, 0, 2'd0, 0);
    drv(0, NOP, 0, NOP, 0, 0, 0);
    cyc("ec_drain2", 1, 1, 1, 0, 2'd0, 0);
    cyc("ec_drain3", 1, 1, 1, 0, 2'd0, 0);
    cyc("ec_redirect", 0, 0, 1, 1, 2'd2, 1);
    cyc("ec_run", 0, 0, 0, 0, 2'd0, 0);

    // ECALL with one MEM_STALL cycle mid-drain.
    drv(1, ECALL, 0, NOP, 0, 0, 0);
    cyc("ecm_issue", 0, 0, 0, 0, 2'd0, 0);
    drv(0, NOP, 0, NOP, 0, 0, 0);
    cyc("ecm_drain1", 1, 1, 1, 0, 2'd0, 0);
    drv(0, NOP, 0, NOP, 1, 0, 0);
    cyc("ecm_stall", 1, 1, 0, 0, 2'd0, 0);
    drv(0, NOP, 0, NOP, 0, 0, 0);
    cyc("ecm_drain2", 1, 1, 1, 0, 2'd0, 0);
    cyc("ecm_drain3", 1, 1, 1, 0, 2'd0, 0);
    cyc("ecm_redirect", 0, 0, 1, 1, 2'd2, 1);
    cyc("ecm_run", 0, 0, 0, 0, 2'd0, 0);

    // Asynchronous reset asserted mid-drain.
    drv(1, ECALL, 0, NOP, 0, 0, 0);
    cyc("rm_issue", 0, 0, 0, 0, 2'd0, 0);
    drv(0, NOP, 0, NOP, 0, 0, 0);
    cyc("rm_drain1", 1, 1, 1, 0, 2'd0, 0);
    cyc("rm_drain2", 1, 1, 1, 0, 2'd0, 0);
    reset = 1'b1;
    drv(1, ADD_R5, 1, LD_X5, 0, 0, 0);
    cyc("rm_reset", 0, 0, 0, 0, 2'd0, 0);
    reset = 1'b0;
    cyc("rm_first", 0, 0, 0, 0, 2'd0, 0);
    drv(0, NOP, 0, NOP, 0, 0, 0);
    cyc("rm_in_run", 0, 0, 0, 0, 2'd0, 0);

    // Long branch wait: 4-bit counter pins at 15, 32-bit keeps counting.
    drv(1, BEQ, 0, NOP, 0, 0, 0);
    cyc("sat_issue", 0, 0, 0, 0, 2'd0, 0);
    drv(0, NOP, 0, NOP, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      cyc("sat_wait", 1, 1, 1, 0, 2'd0, 0);
    end
    drv(0, NOP, 0, NOP, 0, 1, 1);
    cyc("sat_resolve", 0, 1, 1, 1, 2'd1, 0);
    drv(0, NOP, 0, NOP, 0, 0, 0);
    cyc("sat_run", 0, 0, 0, 0, 2'd0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
